// File: rtl/or1200_encryption_pad_engine.sv
// Counter-mode one-time-pad engine for the OR1200 load/store path.
// Seed fields plus an auto-incrementing counter form the request block
// handed to an external AES core; returned pads are prefetched into a
// small FIFO and a DW-bit lane of the head pad is XORed onto LSU data.
module or1200_encryption_pad_engine #(
    parameter int DW    = 32,
    parameter int PAD_W = 128,
    parameter int DEPTH = 4,
    parameter int CTR_W = 32,
    localparam int NLANE = PAD_W / DW,
    localparam int SEL_W = (NLANE > 1) ? $clog2(NLANE) : 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [2:0]       seed_sel,
    input  logic [DW-1:0]    seed_data,
    input  logic             start,
    input  logic             stop,
    output logic             cipher_ld,
    output logic [PAD_W-1:0] cipher_text,
    input  logic             cipher_done,
    input  logic [PAD_W-1:0] cipher_pad,
    input  logic [DW-1:0]    data_in,
    input  logic             data_req,
    input  logic [SEL_W-1:0] word_sel,
    input  logic             pop,
    output logic [DW-1:0]    data_out,
    output logic             pad_valid,
    output logic             unstall,
    output logic [CNT_W-1:0] pad_count,
    output logic             ctr_wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CTR_W-1:0]   row_base;
    logic [CTR_W-1:0]   ctr;
    logic [15:0]        col;
    logic [15:0]        tb;
    logic [7:0]         db;
    logic [15:0]        usr;
    logic               run;
    logic               run_nxt;
    logic               discard;

    logic [PAD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               push_ok;
    logic               pop_ok;
    logic               load_text;
    logic [PAD_W-1:0]   head;
    logic [DW-1:0]      lane;

    // Qualified FIFO strobes; start flushes, so it masks both push and pop
    always_comb begin
        run_nxt   = start ? 1'b1 : (stop ? 1'b0 : run);
        pop_ok    = pop && (count != '0) && !start;
        push_ok   = (state == WAIT) && cipher_done && !discard && !start;
        count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Request FSM: at most one AES request outstanding
    always_comb begin
        state_nxt = state;
        cipher_ld = 1'b0;
        case (state)
            IDLE: begin
                if (run && !stop && !start && (count < CNT_W'(DEPTH)))
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                cipher_ld = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cipher_done) begin
                    // a start racing the completion drops the pad and re-arms from IDLE
                    if (!start && run_nxt && (count_nxt < CNT_W'(DEPTH)))
                        state_nxt = ISSUE;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load_text = (state_nxt == ISSUE);

    // Control state: FSM, seeds, counter, run/discard flags, FIFO pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            row_base <= '0;
            ctr      <= '0;
            col      <= '0;
            tb       <= '0;
            db       <= '0;
            usr      <= '0;
            run      <= 1'b0;
            discard  <= 1'b0;
            ctr_wrap <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            if (seed_we) begin
                case (seed_sel)
                    3'd0:    row_base <= CTR_W'(seed_data);
                    3'd1:    col      <= seed_data[15:0];
                    3'd2:    tb       <= seed_data[15:0];
                    3'd3:    db       <= seed_data[7:0];
                    3'd4:    usr      <= seed_data[15:0];
                    default: ;
                endcase
            end
            if (start) begin
                ctr      <= row_base;
                ctr_wrap <= 1'b0;
                // a request already on its way to the core belongs to the old stream
                discard  <= (state == ISSUE) || ((state == WAIT) && !cipher_done);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (state == ISSUE) begin
                    ctr <= ctr + 1'b1;
                    if (&ctr)
                        ctr_wrap <= 1'b1;
                end
                if ((state == WAIT) && cipher_done)
                    discard <= 1'b0;
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
            end
        end
    end

    // Datapath registers: pad storage and the held request block
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= cipher_pad;
        if (load_text)
            cipher_text <= PAD_W'({usr, db, tb, col, ctr});
    end

    // Lane select of the head pad
    always_comb begin
        head = mem[rd_ptr];
        lane = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (word_sel == SEL_W'(i))
                lane = head[i*DW +: DW];
        end
    end

    assign pad_valid = (count != '0);
    assign pad_count = count;
    assign data_out  = pad_valid ? (data_in ^ lane) : data_in;
    assign unstall   = !(data_req && !pad_valid);

endmodule

// File: tb/tb_or1200_encryption_pad_engine.sv
// Bench for or1200_encryption_pad_engine: directed scenarios followed by a
// randomized phase, all checked against a queue-based behavioural model
// and a latency-3 AES stand-in.
module tb_or1200_encryption_pad_engine;

    localparam int DW    = 32;
    localparam int PAD_W = 128;
    localparam int DEPTH = 4;
    localparam int CTR_W = 32;
    localparam int SEL_W = 2;
    localparam int CNT_W = 3;
    localparam int LAT   = 3;

    typedef logic [PAD_W-1:0] w_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             seed_we;
    logic [2:0]       seed_sel;
    logic [DW-1:0]    seed_data;
    logic             start;
    logic             stop;
    logic             cipher_ld;
    logic [PAD_W-1:0] cipher_text;
    logic             cipher_done;
    logic [PAD_W-1:0] cipher_pad;
    logic [DW-1:0]    data_in;
    logic             data_req;
    logic [SEL_W-1:0] word_sel;
    logic             pop;
    logic [DW-1:0]    data_out;
    logic             pad_valid;
    logic             unstall;
    logic [CNT_W-1:0] pad_count;
    logic             ctr_wrap;

    always #5 clk = ~clk;

    or1200_encryption_pad_engine #(
        .DW(DW), .PAD_W(PAD_W), .DEPTH(DEPTH), .CTR_W(CTR_W)
    ) dut (
        .clk(clk), .rst(rst), .seed_we(seed_we), .seed_sel(seed_sel),
        .seed_data(seed_data), .start(start), .stop(stop),
        .cipher_ld(cipher_ld), .cipher_text(cipher_text),
        .cipher_done(cipher_done), .cipher_pad(cipher_pad),
        .data_in(data_in), .data_req(data_req), .word_sel(word_sel),
        .pop(pop), .data_out(data_out), .pad_valid(pad_valid),
        .unstall(unstall), .pad_count(pad_count), .ctr_wrap(ctr_wrap)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [PAD_W-1:0] q[$];
    logic [CTR_W-1:0] ld_log[$];
    logic [PAD_W-1:0] txt_log[$];
    logic [CTR_W-1:0] m_row, m_ctr;
    logic [15:0]      m_col, m_tb, m_usr, p_col, p_tb, p_usr;
    logic [7:0]       m_db, p_db;
    bit               m_run, m_out, m_disc, m_wrap;

    // AES stand-in
    bit               aes_pend;
    int               aes_wait;
    logic [PAD_W-1:0] aes_text, aes_val;
    bit               rand_mask;

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_of(input logic [PAD_W-1:0] p, input int k);
        return DW'(p >> (k * DW));
    endfunction

    function automatic logic [PAD_W-1:0] exp_text(input logic [CTR_W-1:0] c);
        return PAD_W'({p_usr, p_db, p_tb, p_col, c});
    endfunction

    function automatic logic [PAD_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic reset_model();
        q.delete();
        m_row = '0; m_ctr = '0;
        m_col = '0; m_tb = '0; m_usr = '0; m_db = '0;
        p_col = '0; p_tb = '0; p_usr = '0; p_db = '0;
        m_run = 0; m_out = 0; m_disc = 0; m_wrap = 0;
        aes_pend = 0; aes_wait = 0;
        cipher_done = 1'b0;
    endtask

    // one clock: check outputs mid-cycle, then advance model across the edge
    task automatic step();
        bit               s_ld, s_done, s_start, s_stop, s_pop, s_we;
        logic [PAD_W-1:0] s_text, s_pad;
        logic [2:0]       s_sel;
        logic [DW-1:0]    s_sd, exp_out;
        #1;
        exp_out = (q.size() != 0) ? (data_in ^ lane_of(q[0], int'(word_sel))) : data_in;
        chk("pad_count", w_t'(pad_count), w_t'(q.size()));
        chk("pad_valid", w_t'(pad_valid), w_t'(q.size() != 0));
        chk("unstall", w_t'(unstall), w_t'(!(data_req && q.size() == 0)));
        chk("data_out", w_t'(data_out), w_t'(exp_out));
        chk("ctr_wrap", w_t'(ctr_wrap), w_t'(m_wrap));
        if (aes_pend)
            chk("text_hold", cipher_text, aes_text);
        if (cipher_ld === 1'b1) begin
            chk("ld_allowed", w_t'({m_run, !m_out, q.size() < DEPTH}), w_t'(3'b111));
            chk("cipher_text", cipher_text, exp_text(m_ctr));
        end
        s_ld = (cipher_ld === 1'b1); s_text = cipher_text;
        s_done = cipher_done; s_pad = cipher_pad;
        s_start = start; s_stop = stop; s_pop = pop;
        s_we = seed_we; s_sel = seed_sel; s_sd = seed_data;
        @(posedge clk);
        #1;
        if (!rst) begin
            reset_model();
        end else begin
            if (s_pop && !s_start && q.size() != 0)
                void'(q.pop_front());
            if (s_done && m_out) begin
                if (!s_start && !m_disc)
                    q.push_back(s_pad);
                m_out = 0; m_disc = 0;
            end
            if (s_ld) begin
                ld_log.push_back(m_ctr);
                txt_log.push_back(s_text);
                if (&m_ctr) m_wrap = 1;
                m_ctr = m_ctr + 1'b1;
                m_out = 1; m_disc = 0;
            end
            if (s_start) begin
                q.delete();
                m_ctr = m_row; m_run = 1; m_wrap = 0;
                if (m_out) m_disc = 1;
            end else if (s_stop) begin
                m_run = 0;
            end
            p_col = m_col; p_tb = m_tb; p_usr = m_usr; p_db = m_db;
            if (s_we) begin
                case (s_sel)
                    3'd0: m_row = s_sd;
                    3'd1: m_col = s_sd[15:0];
                    3'd2: m_tb  = s_sd[15:0];
                    3'd3: m_db  = s_sd[7:0];
                    3'd4: m_usr = s_sd[15:0];
                    default: ;
                endcase
            end
            cipher_done = 1'b0;
            if (s_ld) begin
                aes_pend = 1; aes_wait = LAT; aes_text = s_text;
                aes_val = s_text ^ (rand_mask ? rnd128() : '0);
            end else if (aes_pend) begin
                aes_wait--;
                if (aes_wait == 0) begin
                    cipher_done = 1'b1; cipher_pad = aes_val; aes_pend = 0;
                end
            end
        end
        start = 1'b0; stop = 1'b0; seed_we = 1'b0; pop = 1'b0;
    endtask

    task automatic seed(input logic [2:0] sel, input logic [DW-1:0] val);
        seed_we = 1'b1; seed_sel = sel; seed_data = val;
        step();
    endtask

    task automatic wait_count(input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (pad_count == CNT_W'(n)) break;
            step();
        end
        chk(tag, w_t'(pad_count), w_t'(n));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cipher_done) break;
            step();
        end
        chk("done_seen", w_t'(cipher_done), w_t'(1'b1));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!pad_valid) break;
            pop = 1'b1;
            step();
        end
        chk("drained", w_t'(pad_valid), w_t'(1'b0));
    endtask

    initial begin
        int n0;
        rst = 1'b0; seed_we = 0; seed_sel = '0; seed_data = '0;
        start = 0; stop = 0; cipher_done = 0; cipher_pad = '0;
        data_in = 32'h1234_5678; data_req = 0; word_sel = '0; pop = 0;
        rand_mask = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_count", w_t'(pad_count), w_t'(0));
        chk("rst_valid", w_t'(pad_valid), w_t'(0));
        chk("rst_ld", w_t'(cipher_ld), w_t'(0));
        chk("rst_wrap", w_t'(ctr_wrap), w_t'(0));
        chk("rst_unstall", w_t'(unstall), w_t'(1));
        chk("rst_dout", w_t'(data_out), w_t'(32'h1234_5678));
        rst = 1'b1;
        step();

        // seeds, then fill the FIFO
        seed(3'd0, 32'h10); seed(3'd1, 32'hA); seed(3'd2, 32'hB);
        seed(3'd3, 32'hC);  seed(3'd4, 32'hD);
        ld_log.delete(); txt_log.delete();
        start = 1'b1; step();
        wait_count(4, 80, "fill4");
        repeat (12) step();
        chk("ld_total", w_t'(ld_log.size()), w_t'(4));
        for (int k = 0; k < 4; k++)
            chk("ld_ctr", w_t'(ld_log[k]), w_t'(32'h10 + k));
        chk("first_text", txt_log[0], {40'h0, 16'hD, 8'hC, 16'hB, 16'hA, 32'h10});

        // lane selection and pop/refill
        data_in = 32'hFFFF_FFFF; word_sel = 2'd0; #1;
        chk("lane0", w_t'(data_out), w_t'(32'hFFFF_FFEF));
        word_sel = 2'd1; #1;
        chk("lane1", w_t'(data_out), w_t'(32'hFFF4_FFF5));
        word_sel = 2'd0;
        pop = 1'b1; step();
        chk("after_pop", w_t'(data_out), w_t'(32'hFFFF_FFEE));
        wait_count(4, 40, "refill");
        repeat (4) step();
        chk("refill_lds", w_t'(ld_log.size()), w_t'(5));
        chk("refill_ctr", w_t'(ld_log[4]), w_t'(32'h14));

        // stall while empty after a flush
        data_req = 1'b1; start = 1'b1; step();
        chk("stalled", w_t'(unstall), w_t'(0));
        wait_count(1, 40, "first_pad");
        chk("unstalled", w_t'(unstall), w_t'(1));
        data_req = 1'b0;

        // counter wrap
        seed(3'd0, 32'hFFFF_FFFE);
        ld_log.delete();
        start = 1'b1; step();
        wait_count(4, 80, "wrap_fill");
        chk("wrap_c0", w_t'(ld_log[0]), w_t'(32'hFFFF_FFFE));
        chk("wrap_c1", w_t'(ld_log[1]), w_t'(32'hFFFF_FFFF));
        chk("wrap_c2", w_t'(ld_log[2]), w_t'(32'h0));
        chk("wrap_c3", w_t'(ld_log[3]), w_t'(32'h1));
        chk("wrap_set", w_t'(ctr_wrap), w_t'(1));
        start = 1'b1; step();
        chk("wrap_clr", w_t'(ctr_wrap), w_t'(0));

        // restart while a request is in flight
        seed(3'd0, 32'h100);
        for (int i = 0; i < 20; i++) begin
            if (m_out) break;
            step();
        end
        step();
        n0 = ld_log.size();
        start = 1'b1; step();
        chk("disc_empty", w_t'(pad_count), w_t'(0));
        wait_count(1, 60, "disc_refill");
        chk("disc_next_ctr", w_t'(ld_log[n0]), w_t'(32'h100));
        data_in = '0; word_sel = 2'd0; #1;
        chk("disc_head", w_t'(data_out), w_t'(32'h100));

        // stop keeps buffered pads and issues nothing new
        wait_count(2, 40, "stop_at2");
        stop = 1'b1; step();
        repeat (8) step();
        n0 = ld_log.size();
        repeat (10) step();
        chk("stop_no_ld", w_t'(ld_log.size()), w_t'(n0));
        drain(8);

        // pop coincident with a completion
        start = 1'b1; step();
        wait_count(4, 80, "sim_fill");
        pop = 1'b1; step();
        wait_done(20);
        pop = 1'b1; step();
        chk("same_cycle_cnt", w_t'(pad_count), w_t'(3));
        stop = 1'b1; step();
        repeat (8) step();
        drain(8);
        pop = 1'b1; step();
        chk("pop_empty", w_t'(pad_count), w_t'(0));

        // randomized traffic
        rand_mask = 1;
        seed(3'd1, $urandom); seed(3'd2, $urandom); seed(3'd3, $urandom);
        seed(3'd4, $urandom); seed(3'd0, $urandom);
        start = 1'b1; step();
        for (int c = 0; c < 800; c++) begin
            int r;
            data_in  = $urandom;
            data_req = 1'($urandom_range(0, 1));
            word_sel = 2'($urandom_range(0, 3));
            pop      = ($urandom_range(0, 99) < 35);
            r = $urandom_range(0, 99);
            if (r < 2) start = 1'b1;
            else if (r < 4) stop = 1'b1;
            else if (r < 8) start = 1'b1;
            if ($urandom_range(0, 99) < 5) begin
                seed_we = 1'b1;
                seed_sel = 3'($urandom_range(0, 7));
                seed_data = $urandom;
            end
            step();
        end

        // reset in the middle of operation
        start = 1'b1; step();
        repeat (6) step();
        rst = 1'b0; #1;
        chk("mrst_count", w_t'(pad_count), w_t'(0));
        chk("mrst_ld", w_t'(cipher_ld), w_t'(0));
        chk("mrst_wrap", w_t'(ctr_wrap), w_t'(0));
        reset_model();
        step(); step();
        rst = 1'b1;
        repeat (6) step();
        chk("post_rst_idle", w_t'(pad_count), w_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
